// File: rtl/mesh_term_injector_if.sv
// mesh_term_injector_if: host push port and mesh terminal port of the injector
interface mesh_term_injector_if #(
    parameter int pckg_sz = 32,
    parameter int fifo_depth = 8
);
    logic wr_en;
    logic [3:0] wr_row;
    logic [3:0] wr_col;
    logic wr_mode;
    logic wr_bcst;
    logic [pckg_sz-18:0] wr_payload;
    logic full;
    logic [$clog2(fifo_depth):0] count;
    logic [pckg_sz-1:0] data_out_i_in;
    logic pndng_i_in;
    logic popin;
    logic [15:0] sent_cnt;
    logic [15:0] drop_cnt;
    logic err_spurious;
    modport master (
        output wr_en, wr_row, wr_col, wr_mode, wr_bcst, wr_payload, popin,
        input full, count, data_out_i_in, pndng_i_in, sent_cnt, drop_cnt, err_spurious
    );
    modport slave (
        input wr_en, wr_row, wr_col, wr_mode, wr_bcst, wr_payload, popin,
        output full, count, data_out_i_in, pndng_i_in, sent_cnt, drop_cnt, err_spurious
    );
endinterface

// File: rtl/mesh_term_injector.sv
// mesh_term_injector: buffers host packets and presents them one at a time to a mesh terminal
module mesh_term_injector #(
    parameter int pckg_sz = 32,
    parameter int fifo_depth = 8,
    parameter logic [7:0] bdcst = 8'hFF
) (
    input logic clk,
    input logic reset,
    mesh_term_injector_if.slave bus
);
    localparam int aw = $clog2(fifo_depth);
    localparam logic [aw:0] depth = (aw+1)'(fifo_depth);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    state_t state;
    logic [pckg_sz-1:0] mem [fifo_depth];
    logic [aw-1:0] rd_ptr;
    logic [aw-1:0] wr_ptr;
    logic [aw:0] cnt;
    logic [pckg_sz-1:0] pkt;
    logic pop;
    logic push;
    assign pkt = {bus.wr_bcst ? bdcst : 8'h00, bus.wr_row, bus.wr_col, bus.wr_mode, bus.wr_payload};
    assign pop = state == SEND && bus.popin;
    // a full buffer still accepts when the head leaves in the same cycle
    assign push = bus.wr_en && (cnt != depth || pop);
    assign bus.full = cnt == depth;
    assign bus.count = cnt;
    always_ff @(posedge clk)
        if (!reset && push) mem[wr_ptr] <= pkt;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt <= '0;
            bus.pndng_i_in <= 1'b0;
            bus.data_out_i_in <= '0;
            bus.sent_cnt <= '0;
            bus.drop_cnt <= '0;
            bus.err_spurious <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (aw+1)'(push) - (aw+1)'(pop);
            if (pop) bus.sent_cnt <= bus.sent_cnt + 16'd1;
            if (bus.wr_en && !push) bus.drop_cnt <= bus.drop_cnt + 16'd1;
            if (bus.popin && state != SEND) bus.err_spurious <= 1'b1;
            if (state == SEND) begin
                if (pop) begin
                    state <= GAP;
                    bus.pndng_i_in <= 1'b0;
                    bus.data_out_i_in <= '0;
                end
            end else if (cnt != '0 || push) begin
                // no pop outside SEND, so the head is either stored or arriving now
                state <= SEND;
                bus.pndng_i_in <= 1'b1;
                bus.data_out_i_in <= cnt != '0 ? mem[rd_ptr] : pkt;
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mesh_term_injector.sv
// tb_mesh_term_injector: scoreboard bench for the mesh terminal injector
module tb_mesh_term_injector;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    mesh_term_injector_if #(.pckg_sz(32), .fifo_depth(8)) bus ();
    mesh_term_injector #(.pckg_sz(32), .fifo_depth(8), .bdcst(8'hFF)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    logic [31:0] sb [$];
    int checks = 0;
    int errors = 0;
    logic [15:0] m_sent = 16'd0;
    logic [15:0] m_drop = 16'd0;
    logic m_err = 1'b0;
    logic last_pop = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic verify();
        logic pend;
        pend = sb.size() > 0 && !last_pop;
        check("pndng", 32'(bus.pndng_i_in), 32'(pend));
        check("data", bus.data_out_i_in, pend ? sb[0] : 32'h0);
        check("count", 32'(bus.count), 32'(sb.size()));
        check("full", 32'(bus.full), 32'(sb.size() == 8));
        check("sent_cnt", 32'(bus.sent_cnt), 32'(m_sent));
        check("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
        check("err_spurious", 32'(bus.err_spurious), 32'(m_err));
    endtask

    task automatic step(input logic wr, input logic bcst, input logic [3:0] row, input logic [3:0] col,
                        input logic mode, input logic [14:0] pl, input logic pop);
        logic ok;
        logic acc;
        verify();
        ok = pop && sb.size() > 0 && !last_pop;
        acc = wr && (sb.size() < 8 || ok);
        bus.wr_en = wr;
        bus.wr_bcst = bcst;
        bus.wr_row = row;
        bus.wr_col = col;
        bus.wr_mode = mode;
        bus.wr_payload = pl;
        bus.popin = pop;
        if (pop && !ok) m_err = 1'b1;
        if (ok) begin
            void'(sb.pop_front());
            m_sent++;
        end
        if (acc) sb.push_back({bcst ? 8'hFF : 8'h00, row, col, mode, pl});
        else if (wr) m_drop++;
        last_pop = ok;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 15'h0, 1'b0);
    endtask

    task automatic drain(input int n);
        repeat (n) step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 15'h0, sb.size() > 0 && !last_pop);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.wr_en = 1'b1;
        bus.popin = 1'b1;
        bus.wr_payload = 15'h7FFF;
        @(negedge clk);
        @(negedge clk);
        check("rst_pndng", 32'(bus.pndng_i_in), 32'h0);
        check("rst_data", bus.data_out_i_in, 32'h0);
        check("rst_count", 32'(bus.count), 32'h0);
        check("rst_full", 32'(bus.full), 32'h0);
        check("rst_sent", 32'(bus.sent_cnt), 32'h0);
        check("rst_drop", 32'(bus.drop_cnt), 32'h0);
        check("rst_err", 32'(bus.err_spurious), 32'h0);
        reset = 1'b0;
        bus.wr_en = 1'b0;
        bus.popin = 1'b0;
        sb.delete();
        m_sent = 16'd0;
        m_drop = 16'd0;
        m_err = 1'b0;
        last_pop = 1'b0;
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_bcst = 1'b0;
        bus.wr_row = 4'h0;
        bus.wr_col = 4'h0;
        bus.wr_mode = 1'b0;
        bus.wr_payload = 15'h0;
        bus.popin = 1'b0;
        do_reset();
        // single packet: first edge after reset, presented next cycle
        step(1'b1, 1'b0, 4'hF, 4'hF, 1'b1, 15'h5515, 1'b0);
        check("first_pndng", 32'(bus.pndng_i_in), 32'h1);
        check("first_data", bus.data_out_i_in, 32'h00FF_D515);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 15'h0, 1'b1);
        check("after_pop_pndng", 32'(bus.pndng_i_in), 32'h0);
        check("after_pop_sent", 32'(bus.sent_cnt), 32'h1);
        idle(2);
        // fill to full, overflow, then push and pop together while full
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'(i), 4'h1, 1'b0, 15'(256 + i), 1'b0);
        check("full8", 32'(bus.full), 32'h1);
        check("count8", 32'(bus.count), 32'h8);
        step(1'b1, 1'b0, 4'h9, 4'h9, 1'b0, 15'h0999, 1'b0);
        check("drop1", 32'(bus.drop_cnt), 32'h1);
        check("count_after_drop", 32'(bus.count), 32'h8);
        step(1'b1, 1'b0, 4'hA, 4'hA, 1'b1, 15'h0AAA, 1'b1);
        check("count_pushpop", 32'(bus.count), 32'h8);
        check("drop_unchanged", 32'(bus.drop_cnt), 32'h1);
        drain(20);
        check("drained", 32'(bus.count), 32'h0);
        // broadcast header
        step(1'b1, 1'b1, 4'h2, 4'h3, 1'b0, 15'h1234, 1'b0);
        check("bcst_hdr", 32'(bus.data_out_i_in[31:24]), 32'hFF);
        drain(4);
        // spurious popin while idle
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 15'h0, 1'b1);
        check("err_set", 32'(bus.err_spurious), 32'h1);
        check("sent_unchanged", 32'(bus.sent_cnt), 32'(m_sent));
        do_reset();
        // reset with three buffered packets while presenting
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h5, 4'(i), 1'b1, 15'(i * 7 + 3), 1'b0);
        check("pre_reset_pndng", 32'(bus.pndng_i_in), 32'h1);
        check("pre_reset_count", 32'(bus.count), 32'h3);
        do_reset();
        // random traffic against the scoreboard
        repeat (300) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                          1'($urandom_range(0, 1)), 15'($urandom), 1'($urandom_range(0, 1)));
        drain(20);
        verify();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mesh_term_injector.md
MESH_TERM_INJECTOR -- requirements
Module: mesh_term_injector

Interface
REQ-001 SHALL have parameter pckg_sz, default 32, packet width in bits (min 24).
REQ-002 SHALL have parameter fifo_depth, default 8, packet buffer entries (power of two, min 2).
REQ-003 SHALL have parameter bdcst, default 8'hFF, next-jump value marking a broadcast packet.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port wr_en  input  1  host push strobe.
REQ-007 SHALL have port wr_row  input  4  destination row id.
REQ-008 SHALL have port wr_col  input  4  destination column id.
REQ-009 SHALL have port wr_mode  input  1  routing mode bit.
REQ-010 SHALL have port wr_bcst  input  1  broadcast request.
REQ-011 SHALL have port wr_payload  input  pckg_sz-17  packet payload.
REQ-012 SHALL have port full  output  1  buffer holds fifo_depth packets.
REQ-013 SHALL have port count  output  $clog2(fifo_depth)+1  buffered packets, including the one presented.
REQ-014 SHALL have port data_out_i_in  output  pckg_sz  packet presented to mesh terminal.
REQ-015 SHALL have port pndng_i_in  output  1  packet valid toward mesh.
REQ-016 SHALL have port popin  input  1  mesh consume strobe for presented packet.
REQ-017 SHALL have port sent_cnt  output  16  packets consumed by mesh.
REQ-018 SHALL have port drop_cnt  output  16  pushes rejected because full.
REQ-019 SHALL have port err_spurious  output  1  sticky: popin seen while not presenting.

Function
REQ-020 SHALL assemble packet as {nxt_jump[pckg_sz-1:pckg_sz-8], wr_row, wr_col, wr_mode, wr_payload}; nxt_jump = bdcst if wr_bcst=1, else 8'h00.
REQ-021 SHALL accept a push when wr_en=1 and (full=0, or popin=1 in SEND same cycle); otherwise drop, drop_cnt +1.
REQ-022 SHALL implement FSM states IDLE, SEND, GAP; pndng_i_in=1 only in SEND, registered (no combinational input-to-output path).
REQ-023 IDLE: pndng_i_in=0; go SEND when buffer non-empty or push accepted this cycle.
REQ-024 SEND: data_out_i_in = head packet, stable while in SEND; on popin=1 pop head, sent_cnt +1, go GAP.
REQ-025 GAP: pndng_i_in=0 for exactly one cycle; then SEND if buffer non-empty after this cycle's updates, else IDLE.
REQ-026 Push into empty buffer in IDLE at cycle N SHALL give pndng_i_in=1 with that packet on data_out_i_in at cycle N+1.
REQ-027 Back-to-back: consecutive packets SHALL be presented at 2-cycle intervals minimum (SEND, GAP).
REQ-028 popin=1 in IDLE or GAP SHALL not pop, not change sent_cnt, and set err_spurious.
REQ-029 Simultaneous push and popin in SEND SHALL pop and push; count unchanged; order preserved (FIFO).
REQ-030 sent_cnt and drop_cnt SHALL wrap 16'hFFFF -> 16'h0000.
REQ-031 data_out_i_in SHALL be 0 when not in SEND.

Reset
REQ-032 reset=1 at a rising edge SHALL force IDLE, empty buffer, count=0, full=0, pndng_i_in=0, data_out_i_in=0, sent_cnt=0, drop_cnt=0, err_spurious=0.
REQ-033 reset mid-SEND SHALL discard all buffered packets; wr_en and popin during reset cycles SHALL be ignored.
REQ-034 First push accepted on the first edge with reset=0.

Verification
REQ-035 Push row=4'hF col=4'hF mode=1 payload=15'h5515 bcst=0 into idle -> next cycle pndng_i_in=1, data_out_i_in=32'h00FF_D515; popin -> pndng_i_in=0 next cycle, sent_cnt=1.
REQ-036 Push 8 packets, no popin -> full=1, count=8; 9th push -> drop_cnt=1, count stays 8; drain -> payloads in push order, pndng_i_in low one cycle between each.
REQ-037 Full buffer, push with popin in SEND -> accepted, count=8, drop_cnt unchanged.
REQ-038 wr_bcst=1 push -> data_out_i_in[31:24]=8'hFF.
REQ-039 popin pulse while IDLE -> err_spurious=1, sent_cnt unchanged; reset clears it.
REQ-040 3 packets buffered, reset asserted in SEND -> next cycle pndng_i_in=0, count=0, all counters 0.
